pic_int_sequencer: RTL

PIC_INT_SEQUENCER -- requirements
Module: pic_int_sequencer

---
 rtl/pic_int_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pic_int_sequencer.sv
// 8-input interrupt sequencer: request capture, priority resolution, two-pulse INTA vector delivery.
// Latency: irr one cycle after an IR edge, int_out one cycle after eligibility, vec_oe one cycle after 2nd INTA fall.
// Backpressure: none; the CPU paces the acknowledge through inta_n, and the block waits indefinitely in PEND/GAP.
module pic_int_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir,
  input  logic [7:0] imr,
  input  logic       ltim,
  input  logic [4:0] vec_base,
  input  logic       aeoi,
  input  logic       inta_n,
  input  logic       eoi_stb,
  input  logic       eoi_sl,
  input  logic       eoi_rot,
  input  logic [2:0] eoi_lvl,
  output logic       int_out,
  output logic [7:0] vec_out,
  output logic       vec_oe,
  output logic [7:0] irr,
  output logic [7:0] isr
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PEND = 3'd1,
    ACK1 = 3'd2,
    GAP  = 3'd3,
    ACK2 = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] ir_q;     // edge-detect history of the request lines
  logic       inta_q;   // previous sampled inta_n
  logic [2:0] lp;       // lowest-priority level; lp+1 is the highest
  logic [2:0] level;    // level captured at the first acknowledge
  logic       spur;     // first acknowledge found no candidate

  // Scan from the highest-priority level downward; returns {found, level}.
  function automatic logic [3:0] find_top(input logic [7:0] v, input logic [2:0] p);
    logic [3:0] r;
    logic [2:0] l;
    r = 4'd0;
    for (int k = 0; k < 8; k++) begin
      l = p + 3'd1 + 3'(k);
      if (v[l] && !r[3]) r = {1'b1, l};
    end
    return r;
  endfunction

  // Priority rank of a level: 0 is highest, 7 is lowest.
  function automatic logic [2:0] rank(input logic [2:0] l, input logic [2:0] p);
    return l - p - 3'd1;
  endfunction

  logic [3:0] cand;
  logic [3:0] isr_top;
  logic       elig;
  logic       inta_fall;
  logic       inta_rise;
  logic       ack1_take;
  logic [7:0] isr_set;
  logic [7:0] isr_clr;
  logic [7:0] irr_clr;
  logic [7:0] irr_nxt;
  logic [2:0] lp_nxt;

  // Candidate selection, eligibility against in-service, and register update terms.
  always_comb begin
    cand      = find_top(irr & ~imr, lp);
    isr_top   = find_top(isr, lp);
    elig      = cand[3] && (!isr_top[3] || (rank(cand[2:0], lp) < rank(isr_top[2:0], lp)));
    inta_fall = inta_q & ~inta_n;
    inta_rise = ~inta_q & inta_n;
    ack1_take = (state == PEND) && inta_fall && elig;

    isr_set = 8'd0;
    if (ack1_take) isr_set = 8'd1 << cand[2:0];

    isr_clr = 8'd0;
    if (eoi_stb) begin
      if (eoi_sl) isr_clr = 8'd1 << eoi_lvl;
      else if (isr_top[3]) isr_clr = 8'd1 << isr_top[2:0];
    end
    if ((state == ACK2) && inta_rise && aeoi && !spur) isr_clr = isr_clr | (8'd1 << level);

    // Level mode mirrors the lines; edge mode latches rising edges until acknowledged.
    irr_clr = (!ltim && ack1_take) ? isr_set : 8'd0;
    if (ltim) irr_nxt = ir;
    else      irr_nxt = (irr & ~irr_clr) | (ir & ~ir_q);

    lp_nxt = lp;
    if (eoi_stb && eoi_rot) begin
      if (eoi_sl)          lp_nxt = eoi_lvl;
      else if (isr_top[3]) lp_nxt = isr_top[2:0];
    end
  end

  // Request, in-service and priority-pointer registers; a set from the first acknowledge beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irr    <= 8'd0;
      isr    <= 8'd0;
      lp     <= 3'd7;
      ir_q   <= 8'd0;
      inta_q <= 1'b1;
    end else begin
      irr    <= irr_nxt;
      isr    <= (isr & ~isr_clr) | isr_set;
      lp     <= lp_nxt;
      ir_q   <= ir;
      inta_q <= inta_n;
    end
  end

  // Acknowledge sequencer with registered int_out / vec_oe / vec_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      int_out <= 1'b0;
      vec_oe  <= 1'b0;
      vec_out <= 8'd0;
      level   <= 3'd0;
      spur    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (elig) begin
            state   <= PEND;
            int_out <= 1'b1;
          end
        end
        PEND: begin
          if (inta_fall) begin
            state <= ACK1;
            level <= elig ? cand[2:0] : 3'd7;
            spur  <= !elig;
          end
        end
        ACK1: begin
          if (inta_rise) state <= GAP;
        end
        GAP: begin
          if (inta_fall) begin
            state   <= ACK2;
            vec_oe  <= 1'b1;
            vec_out <= {vec_base, level};
          end
        end
        ACK2: begin
          if (inta_rise) begin
            state   <= IDLE;
            int_out <= 1'b0;
            vec_oe  <= 1'b0;
            vec_out <= 8'd0;
          end else begin
            vec_out <= {vec_base, level};
          end
        end
        default: begin
          state   <= IDLE;
          int_out <= 1'b0;
          vec_oe  <= 1'b0;
          vec_out <= 8'd0;
        end
      endcase
    end
  end

endmodule
